bcd_addsub_serial: RTL and testbench

BCD_ADDSUB_SERIAL -- requirements
Module: bcd_addsub_serial

---
 rtl/bcd_pkg.sv | 7 +
 rtl/bcd_digit_addsub.sv | 20 ++
 rtl/bcd_addsub_serial.sv | 95 +++++++++
 tb/tb_bcd_addsub_serial.sv | 136 +++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD digit type, FSM states and digit constants.
package bcd_pkg;
  typedef logic [3:0] bcd_digit_t;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  localparam bcd_digit_t BCD_NINE = 4'd9;
  localparam bcd_digit_t BCD_SIX  = 4'd6;
endpackage

// File: rtl/bcd_digit_addsub.sv
// bcd_digit_addsub: one BCD digit of a + (comp ? 9-b : b) + cin with decimal carry.
module bcd_digit_addsub
  import bcd_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       cin,
  input  logic       comp,
  output bcd_digit_t s,
  output logic       cout
);
  bcd_digit_t bd;
  logic [4:0] sum;
  always_comb begin
    bd = comp ? bcd_digit_t'(BCD_NINE - b) : b;
    sum = {1'b0, a} + {1'b0, bd} + {4'b0, cin};
    cout = sum > 5'd9;
    s = cout ? bcd_digit_t'(sum[3:0] + BCD_SIX) : sum[3:0];
  end
endmodule

// File: rtl/bcd_addsub_serial.sv
// bcd_addsub_serial: digit-serial BCD add/subtract, sign-magnitude result.
// Define BCD_INPUT_CHECK_EN to flag non-BCD input digits on err.
module bcd_addsub_serial
  import bcd_pkg::*;
#(
  parameter int NDIGITS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   op,
  input  logic [4*NDIGITS-1:0]   a,
  input  logic [4*NDIGITS-1:0]   b,
  output logic                   busy,
  output logic                   done,
  output logic [4*NDIGITS-1:0]   result,
  output logic                   neg,
  output logic                   ovf,
  output logic                   err
);
  localparam int W  = 4 * NDIGITS;
  localparam int IW = $clog2(NDIGITS + 1);
  state_t state, state_nx;
  logic [W-1:0] a_sh, b_sh, res;
  logic [IW-1:0] idx;
  logic op_r, carry, neg_r, ovf_r, fix, last, cin, comp, cout;
  bcd_digit_t da, db, s;
  // FIX reuses the digit adder as 0 + nines(res) + 1, i.e. the tens complement
  always_comb begin
    fix = state == FIX;
    last = idx == IW'(NDIGITS - 1);
    da = fix ? '0 : a_sh[3:0];
    db = fix ? res[3:0] : b_sh[3:0];
    comp = fix | op_r;
    cin = (idx == '0) ? (fix | op_r) : carry;
  end
  bcd_digit_addsub u_digit (.a(da), .b(db), .cin(cin), .comp(comp), .s(s), .cout(cout));
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = start ? CALC : IDLE;
      CALC: state_nx = !last ? CALC : (op_r && !cout) ? FIX : DONE;
      FIX:  state_nx = last ? DONE : FIX;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    busy = state != IDLE;
    done = state == DONE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_sh <= '0;
      b_sh <= '0;
      res <= '0;
      idx <= '0;
      op_r <= 1'b0;
      carry <= 1'b0;
      neg_r <= 1'b0;
      ovf_r <= 1'b0;
    end else if (state == IDLE && start) begin
      a_sh <= a;
      b_sh <= b;
      op_r <= op;
      idx <= '0;
      carry <= 1'b0;
    end else if (state == CALC || fix) begin
      a_sh <= a_sh >> 4;
      b_sh <= b_sh >> 4;
      res <= (res >> 4) | (W'(s) << (W - 4));
      carry <= cout;
      idx <= last ? '0 : idx + 1'b1;
      if (!fix && last) begin
        ovf_r <= !op_r & cout;
        neg_r <= op_r & !cout;
      end
    end
  assign result = res;
  assign neg = neg_r;
  assign ovf = ovf_r;
`ifdef BCD_INPUT_CHECK_EN
  logic err_r;
  always_ff @(posedge clk or posedge rst)
    if (rst) err_r <= 1'b0;
    else if (state == IDLE && start) err_r <= 1'b0;
    else if (state == CALC) err_r <= err_r | (a_sh[3:0] > BCD_NINE) | (b_sh[3:0] > BCD_NINE);
  assign err = err_r;
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_bcd_addsub_serial.sv
// tb_bcd_addsub_serial: directed and random ops against an integer-arithmetic model.
module tb_bcd_addsub_serial;
  logic clk = 0, rst = 0, start = 0, op = 0;
  logic [15:0] a = '0, b = '0;
  logic busy, done, neg, ovf, err;
  logic [15:0] result;
  int n_chk = 0, n_pass = 0;
  bcd_addsub_serial #(.NDIGITS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .neg(neg), .ovf(ovf), .err(err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic int b2i(input logic [15:0] v);
    int r = 0;
    for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction
  function automatic logic [15:0] i2b(input int v);
    logic [15:0] r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction
  function automatic bit valid(input logic [15:0] v);
    for (int i = 0; i < 4; i++) if (v[4*i +: 4] > 4'd9) return 0;
    return 1;
  endfunction
  // e counts edges after the accepting edge; done is seen in the cycle ending at edge e
  task automatic run_op(input logic o, input logic [15:0] x, input logic [15:0] y, input bit restart);
    int va, vb, e, exp_lat;
    logic [15:0] exp_res, held;
    logic exp_neg, exp_ovf, exp_err;
    va = b2i(x);
    vb = b2i(y);
    exp_ovf = 0;
    exp_neg = 0;
    exp_lat = 5;
    if (!o) begin
      exp_res = i2b((va + vb) % 10000);
      exp_ovf = (va + vb) > 9999;
    end else if (va >= vb) exp_res = i2b(va - vb);
    else begin
      exp_res = i2b(vb - va);
      exp_neg = 1;
      exp_lat = 9;
    end
`ifdef BCD_INPUT_CHECK_EN
    exp_err = !valid(x) || !valid(y);
`else
    exp_err = 0;
`endif
    @(negedge clk);
    start = 1; op = o; a = x; b = y;
    @(negedge clk);
    start = 0;
    check("busy", busy, 1);
    e = 1;
    while (!done && e < 20) begin
      start = restart && e == 2;
      if (start) begin a = 16'h9999; b = 16'h8888; op = ~o; end
      @(negedge clk);
      e++;
    end
    start = 0;
    check("latency", e, exp_lat);
    check("err", err, exp_err);
    if (valid(x) && valid(y)) begin
      check("result", result, exp_res);
      check("neg", neg, exp_neg);
      check("ovf", ovf, exp_ovf);
    end
    held = result;
    @(negedge clk);
    check("done_pulse", done, 0);
    check("busy_idle", busy, 0);
    check("result_hold", result, held);
  endtask
  initial begin
    bit saw;
    #2 rst = 1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_flags", {neg, ovf, err}, 0);
    #20 rst = 0;
    run_op(0, 16'h1234, 16'h5678, 0);
    run_op(0, 16'h9999, 16'h0001, 0);
    run_op(1, 16'h5000, 16'h1234, 0);
    run_op(1, 16'h0042, 16'h0042, 0);
    run_op(1, 16'h0123, 16'h4567, 0);
    run_op(0, 16'h0000, 16'h0000, 0);
    run_op(1, 16'h0000, 16'h9999, 0);
    run_op(0, 16'h2468, 16'h1357, 1);
    run_op(1, 16'h0007, 16'h0300, 1);
    run_op(0, 16'h00A0, 16'h0001, 0);
    // abort mid-calculation with an asynchronous reset
    @(negedge clk);
    start = 1; op = 0; a = 16'h4321; b = 16'h1111;
    @(negedge clk);
    start = 0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_result", result, 0);
    check("abort_flags", {done, neg, ovf, err}, 0);
    @(negedge clk) rst = 0;
    saw = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) saw = 1;
    end
    check("abort_no_done", saw, 0);
    run_op(0, 16'h0505, 16'h0606, 0);
    repeat (150) begin
      logic [15:0] x, y;
      for (int i = 0; i < 4; i++) begin
        x[4*i +: 4] = 4'($urandom_range(0, 9));
        y[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 9) == 0) y = x;
      run_op(1'($urandom_range(0, 1)), x, y, $urandom_range(0, 7) == 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
